// File: rtl/uart_receive.sv
// uart_receive: serial-to-parallel receiver for 7/8 data bits with optional
// odd/even parity and one stop bit. RX is synchronized, frames are timed from
// a latched copy of BAUD_COUNT, and each completed byte is held with its
// status flags until the consumer acknowledges it with CLR_RXRDY.
module uart_receive (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  input  logic        PEN,
  input  logic        OHEL,
  input  logic        EIGHT,
  input  logic [18:0] BAUD_COUNT,
  input  logic        CLR_RXRDY,
  output logic [7:0]  RX_DATA,
  output logic        RX_RDY,
  output logic        PERR,
  output logic        FERR,
  output logic        OVF
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    COMMIT
  } state_t;

  // Synchronizer
  logic        rx_meta_reg;
  logic        rxs_reg;

  // Frame control
  state_t      state_reg, state_next;
  logic [18:0] cnt_reg, cnt_next;
  logic [3:0]  idx_reg, idx_next;

  // Configuration captured at the start of each frame
  logic        pen_reg;
  logic        ohel_reg;
  logic        eight_reg;
  logic [18:0] baud_reg;

  // Captured line samples
  logic [8:0]  bits_reg;
  logic        stop_reg;

  // Held result
  logic [7:0]  rx_data_reg;
  logic        rx_rdy_reg;
  logic        perr_reg;
  logic        ferr_reg;
  logic        ovf_reg;

  // FSM strobes
  logic        cfg_latch;
  logic        sample_data;
  logic        sample_stop;
  logic        commit;

  // Derived frame values
  logic [18:0] half_m1;
  logic [18:0] full_m1;
  logic [3:0]  nbits;
  logic [8:0]  bit_hit;
  logic [7:0]  data_byte;
  logic        parity_bit;
  logic        perr_calc;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= RX;
      rxs_reg     <= rx_meta_reg;
    end
  end

  // Mid-bit and full-bit compare points, and bits per frame after start
  assign half_m1 = {1'b0, baud_reg[18:1]} - 19'd1;
  assign full_m1 = baud_reg - 19'd1;
  assign nbits   = 4'd7 + {3'b000, eight_reg} + {3'b000, pen_reg};

  // Each captured bit position has its own load strobe, keyed by the bit index
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_bit_hit
      assign bit_hit[gi] = sample_data && (idx_reg == 4'(gi));
    end
  endgenerate

  // Data byte excludes the parity bit; bit 7 only exists in 8-bit frames
  assign data_byte  = {eight_reg & bits_reg[7], bits_reg[6:0]};
  assign parity_bit = pen_reg ? (eight_reg ? bits_reg[8] : bits_reg[7]) : 1'b0;
  assign perr_calc  = pen_reg & ((^data_byte ^ parity_bit) != ohel_reg);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state, bit-time counter/index updates and sample strobes
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    cfg_latch   = 1'b0;
    sample_data = 1'b0;
    sample_stop = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Too-short bit times cannot place a mid-bit sample, so stay put
        if ((BAUD_COUNT >= 19'd4) && !rxs_reg) begin
          state_next = START;
          cnt_next   = '0;
          idx_next   = '0;
          cfg_latch  = 1'b1;
        end
      end
      START: begin
        if (cnt_reg == half_m1) begin
          if (rxs_reg) begin
            // Line went back high before mid start bit: glitch, not a frame
            state_next = IDLE;
          end else begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 19'd1;
        end
      end
      DATA: begin
        if (cnt_reg == full_m1) begin
          sample_data = 1'b1;
          cnt_next    = '0;
          idx_next    = idx_reg + 4'd1;
          if (idx_reg == (nbits - 4'd1)) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 19'd1;
        end
      end
      STOP: begin
        if (cnt_reg == full_m1) begin
          sample_stop = 1'b1;
          cnt_next    = '0;
          state_next  = COMMIT;
        end else begin
          cnt_next = cnt_reg + 19'd1;
        end
      end
      COMMIT: begin
        // Back to IDLE mid stop bit so the next start edge is never missed
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit-time counter and bit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // Frame configuration is frozen for the whole frame once a start is seen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pen_reg   <= 1'b0;
      ohel_reg  <= 1'b0;
      eight_reg <= 1'b0;
      baud_reg  <= '0;
    end else if (cfg_latch) begin
      pen_reg   <= PEN;
      ohel_reg  <= OHEL;
      eight_reg <= EIGHT;
      baud_reg  <= BAUD_COUNT;
    end
  end

  // Capture data/parity samples LSB first; cleared at each new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_reg <= '0;
    end else if (cfg_latch) begin
      bits_reg <= '0;
    end else begin
      bits_reg <= (bits_reg & ~bit_hit) | ({9{rxs_reg}} & bit_hit);
    end
  end

  // Stop bit sample, consumed on the following commit cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stop_reg <= 1'b1;
    end else if (sample_stop) begin
      stop_reg <= rxs_reg;
    end
  end

  // Held byte and status; a commit takes priority over an acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_reg <= '0;
      rx_rdy_reg  <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else if (commit) begin
      rx_data_reg <= data_byte;
      rx_rdy_reg  <= 1'b1;
      perr_reg    <= perr_calc;
      ferr_reg    <= ~stop_reg;
      ovf_reg     <= rx_rdy_reg & ~CLR_RXRDY;
    end else if (CLR_RXRDY) begin
      rx_rdy_reg  <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end
  end

  assign RX_DATA = rx_data_reg;
  assign RX_RDY  = rx_rdy_reg;
  assign PERR    = perr_reg;
  assign FERR    = ferr_reg;
  assign OVF     = ovf_reg;

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: drives serial frames into uart_receive and compares the
// held byte and flags against values computed from the frame contents.
module tb_uart_receive;

  logic        clk;
  logic        reset;
  logic        RX;
  logic        PEN;
  logic        OHEL;
  logic        EIGHT;
  logic [18:0] BAUD_COUNT;
  logic        CLR_RXRDY;
  logic [7:0]  RX_DATA;
  logic        RX_RDY;
  logic        PERR;
  logic        FERR;
  logic        OVF;

  int n_cmp;
  int n_err;

  uart_receive dut (
    .clk        (clk),
    .reset      (reset),
    .RX         (RX),
    .PEN        (PEN),
    .OHEL       (OHEL),
    .EIGHT      (EIGHT),
    .BAUD_COUNT (BAUD_COUNT),
    .CLR_RXRDY  (CLR_RXRDY),
    .RX_DATA    (RX_DATA),
    .RX_RDY     (RX_RDY),
    .PERR       (PERR),
    .FERR       (FERR),
    .OVF        (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_cfg(input bit pen, input bit ohel, input bit eight, input int baud);
    @(negedge clk);
    PEN        = pen;
    OHEL       = ohel;
    EIGHT      = eight;
    BAUD_COUNT = 19'(baud);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    CLR_RXRDY = 1'b1;
    @(negedge clk);
    CLR_RXRDY = 1'b0;
  endtask

  task automatic idle_line(input int cycles);
    RX = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Drive one frame on RX. clr_at >= 0 raises CLR_RXRDY for one cycle at that
  // clock offset into the stop bit; toggle_eight flips EIGHT mid-frame.
  task automatic send_frame(input logic [7:0] data, input bit pen, input bit ohel,
                            input bit eight, input bit par_ok, input bit stop,
                            input int baud, input int clr_at, input bit toggle_eight);
    logic [7:0] dm;
    logic       p;
    int         n;
    dm = eight ? data : (data & 8'h7F);
    p  = (^dm) ^ ohel;
    if (!par_ok) p = ~p;
    n  = eight ? 8 : 7;
    @(negedge clk);
    RX = 1'b0;
    repeat (baud) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      RX = dm[i];
      if (toggle_eight && i == 3) EIGHT = ~EIGHT;
      repeat (baud) @(negedge clk);
    end
    if (pen) begin
      RX = p;
      repeat (baud) @(negedge clk);
    end
    RX = stop;
    for (int i = 0; i < baud; i++) begin
      CLR_RXRDY = (i == clr_at);
      @(negedge clk);
    end
    CLR_RXRDY = 1'b0;
    RX = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    RX = 1'b1; PEN = 1'b0; OHEL = 1'b0; EIGHT = 1'b1;
    BAUD_COUNT = 19'd16; CLR_RXRDY = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (RX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", RX_DATA); end
    n_cmp++; if (RX_RDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", RX_RDY); end
    n_cmp++; if (PERR !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b want 0", PERR); end
    n_cmp++; if (FERR !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", FERR); end
    n_cmp++; if (OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", OVF); end
    $display("test_reset: outputs after reset data=%h rdy=%b", RX_DATA, RX_RDY);
  endtask

  task automatic test_loopback();
    set_cfg(1, 0, 1, 16);
    send_frame(8'hA5, 1, 0, 1, 1, 1, 16, -1, 0);
    n_cmp++; if (RX_DATA !== 8'hA5) begin n_err++; $display("FAIL loop_data got %h want a5", RX_DATA); end
    n_cmp++; if (RX_RDY !== 1'b1) begin n_err++; $display("FAIL loop_rdy got %b want 1", RX_RDY); end
    n_cmp++; if (PERR !== 1'b0) begin n_err++; $display("FAIL loop_perr got %b want 0", PERR); end
    n_cmp++; if (FERR !== 1'b0) begin n_err++; $display("FAIL loop_ferr got %b want 0", FERR); end
    n_cmp++; if (OVF !== 1'b0) begin n_err++; $display("FAIL loop_ovf got %b want 0", OVF); end
    $display("test_loopback: byte a5 received as %h", RX_DATA);
    pulse_clr();
    n_cmp++; if ({RX_RDY, PERR, FERR, OVF} !== 4'b0000) begin n_err++; $display("FAIL clr_flags got %b want 0000", {RX_RDY, PERR, FERR, OVF}); end
    n_cmp++; if (RX_DATA !== 8'hA5) begin n_err++; $display("FAIL clr_data_hold got %h want a5", RX_DATA); end
    $display("test_loopback: after clear flags=%b", {RX_RDY, PERR, FERR, OVF});
    idle_line(16);
  endtask

  task automatic test_parity7();
    set_cfg(1, 1, 0, 16);
    send_frame(8'h7F, 1, 1, 0, 0, 1, 16, -1, 0);
    n_cmp++; if (RX_DATA !== 8'h7F) begin n_err++; $display("FAIL p7_bad_data got %h want 7f", RX_DATA); end
    n_cmp++; if (PERR !== 1'b1) begin n_err++; $display("FAIL p7_bad_perr got %b want 1", PERR); end
    $display("test_parity7: wrong parity perr=%b", PERR);
    pulse_clr();
    idle_line(16);
    send_frame(8'h7F, 1, 1, 0, 1, 1, 16, -1, 0);
    n_cmp++; if (RX_DATA !== 8'h7F) begin n_err++; $display("FAIL p7_ok_data got %h want 7f", RX_DATA); end
    n_cmp++; if (PERR !== 1'b0) begin n_err++; $display("FAIL p7_ok_perr got %b want 0", PERR); end
    $display("test_parity7: correct parity perr=%b", PERR);
    pulse_clr();
    idle_line(16);
  endtask

  task automatic test_framing();
    set_cfg(0, 0, 1, 16);
    send_frame(8'h96, 0, 0, 1, 1, 0, 16, -1, 0);
    n_cmp++; if (FERR !== 1'b1) begin n_err++; $display("FAIL ferr got %b want 1", FERR); end
    n_cmp++; if (RX_DATA !== 8'h96) begin n_err++; $display("FAIL ferr_data got %h want 96", RX_DATA); end
    $display("test_framing: low stop bit ferr=%b", FERR);
    idle_line(48);
    pulse_clr();
    // 5-clock glitch: gone before the mid start-bit sample
    @(negedge clk);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    idle_line(64);
    n_cmp++; if (RX_RDY !== 1'b0) begin n_err++; $display("FAIL glitch_rdy got %b want 0", RX_RDY); end
    n_cmp++; if (RX_DATA !== 8'h96) begin n_err++; $display("FAIL glitch_data got %h want 96", RX_DATA); end
    $display("test_framing: glitch ignored rdy=%b", RX_RDY);
  endtask

  task automatic test_back_to_back();
    set_cfg(0, 0, 1, 16);
    send_frame(8'h11, 0, 0, 1, 1, 1, 16, -1, 0);
    send_frame(8'h22, 0, 0, 1, 1, 1, 16, -1, 0);
    n_cmp++; if (RX_DATA !== 8'h22) begin n_err++; $display("FAIL ovr_data got %h want 22", RX_DATA); end
    n_cmp++; if (OVF !== 1'b1) begin n_err++; $display("FAIL ovr_ovf got %b want 1", OVF); end
    n_cmp++; if (RX_RDY !== 1'b1) begin n_err++; $display("FAIL ovr_rdy got %b want 1", RX_RDY); end
    $display("test_back_to_back: overrun data=%h ovf=%b", RX_DATA, OVF);
    pulse_clr();
    idle_line(16);
    // Second pair: acknowledge lands exactly on the commit cycle of the second frame
    send_frame(8'h33, 0, 0, 1, 1, 1, 16, -1, 0);
    send_frame(8'h44, 0, 0, 1, 1, 1, 16, 3 + 16 / 2, 0);
    n_cmp++; if (RX_DATA !== 8'h44) begin n_err++; $display("FAIL clrcommit_data got %h want 44", RX_DATA); end
    n_cmp++; if (OVF !== 1'b0) begin n_err++; $display("FAIL clrcommit_ovf got %b want 0", OVF); end
    n_cmp++; if (RX_RDY !== 1'b1) begin n_err++; $display("FAIL clrcommit_rdy got %b want 1", RX_RDY); end
    $display("test_back_to_back: clear on commit ovf=%b rdy=%b", OVF, RX_RDY);
    pulse_clr();
    idle_line(16);
  endtask

  task automatic test_reset_midframe();
    set_cfg(0, 0, 1, 16);
    send_frame(8'h5A, 0, 0, 1, 1, 1, 16, -1, 0);
    idle_line(16);
    @(negedge clk);
    RX = 1'b0;
    repeat (16) @(negedge clk);
    RX = 1'b1;
    repeat (48) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({RX_DATA, RX_RDY, PERR, FERR, OVF} !== 12'h000) begin n_err++; $display("FAIL midreset_outputs got %h want 000", {RX_DATA, RX_RDY, PERR, FERR, OVF}); end
    $display("test_reset_midframe: outputs after abort data=%h rdy=%b", RX_DATA, RX_RDY);
    idle_line(200);
    n_cmp++; if (RX_RDY !== 1'b0) begin n_err++; $display("FAIL midreset_no_ghost got %b want 0", RX_RDY); end
    send_frame(8'h3C, 0, 0, 1, 1, 1, 16, -1, 0);
    n_cmp++; if (RX_DATA !== 8'h3C) begin n_err++; $display("FAIL post_reset_data got %h want 3c", RX_DATA); end
    n_cmp++; if (RX_RDY !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy got %b want 1", RX_RDY); end
    $display("test_reset_midframe: following frame data=%h", RX_DATA);
    pulse_clr();
    idle_line(16);
  endtask

  task automatic test_config_latch();
    set_cfg(0, 0, 1, 16);
    send_frame(8'hC3, 0, 0, 1, 1, 1, 16, -1, 1);
    EIGHT = 1'b1;
    n_cmp++; if (RX_DATA !== 8'hC3) begin n_err++; $display("FAIL latch_data got %h want c3", RX_DATA); end
    n_cmp++; if (FERR !== 1'b0) begin n_err++; $display("FAIL latch_ferr got %b want 0", FERR); end
    $display("test_config_latch: toggled EIGHT mid-frame data=%h", RX_DATA);
    pulse_clr();
    idle_line(16);
    set_cfg(0, 0, 1, 2);
    send_frame(8'h00, 0, 0, 1, 1, 1, 16, -1, 0);
    idle_line(32);
    n_cmp++; if (RX_RDY !== 1'b0) begin n_err++; $display("FAIL minbaud_rdy got %b want 0", RX_RDY); end
    $display("test_config_latch: BAUD_COUNT=2 rdy=%b", RX_RDY);
    set_cfg(0, 0, 1, 16);
    idle_line(16);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] exp_d;
    bit         pen, ohel, eight, par_ok, stop;
    int         baud;
    for (int t = 0; t < 24; t++) begin
      d      = 8'($urandom);
      pen    = 1'($urandom);
      ohel   = 1'($urandom);
      eight  = 1'($urandom);
      par_ok = ($urandom_range(3, 0) != 0);
      stop   = ($urandom_range(4, 0) != 0);
      baud   = int'($urandom_range(40, 8));
      exp_d  = eight ? d : {1'b0, d[6:0]};
      set_cfg(pen, ohel, eight, baud);
      send_frame(d, pen, ohel, eight, par_ok, stop, baud, -1, 0);
      n_cmp++; if (RX_DATA !== exp_d) begin n_err++; $display("FAIL rnd%0d_data got %h want %h", t, RX_DATA, exp_d); end
      n_cmp++; if (RX_RDY !== 1'b1) begin n_err++; $display("FAIL rnd%0d_rdy got %b want 1", t, RX_RDY); end
      n_cmp++; if (PERR !== (pen && !par_ok)) begin n_err++; $display("FAIL rnd%0d_perr got %b want %b", t, PERR, pen && !par_ok); end
      n_cmp++; if (FERR !== !stop) begin n_err++; $display("FAIL rnd%0d_ferr got %b want %b", t, FERR, !stop); end
      n_cmp++; if (OVF !== 1'b0) begin n_err++; $display("FAIL rnd%0d_ovf got %b want 0", t, OVF); end
      $display("test_random %0d: d=%h pen=%0d ohel=%0d eight=%0d par_ok=%0d stop=%0d baud=%0d got=%h perr=%b ferr=%b",
               t, d, pen, ohel, eight, par_ok, stop, baud, RX_DATA, PERR, FERR);
      idle_line(2 * baud);
      pulse_clr();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_loopback();
    test_parity7();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_config_latch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial receiver that consumes the `TX` line of the UART transmit stage, or an external RX pin, and recovers parallel bytes. It uses the same frame configuration inputs (`PEN`, `OHEL`, `EIGHT`) and the same `BAUD_COUNT` bit-time value as the transmitter, so a transmit/receive pair loops back with shared controls. Received bytes and their status are held for the memory/processor side until acknowledged.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `RX`  in  1  serial input; idles high; asynchronous to `clk`.
- `PEN`  in  1  parity enable.
- `OHEL`  in  1  parity sense: 1 = odd, 0 = even.
- `EIGHT`  in  1  data bits per frame: 1 = 8 bits, 0 = 7 bits.
- `BAUD_COUNT`  in  19  number of clocks per bit.
- `CLR_RXRDY`  in  1  one-cycle read acknowledge from the consumer.
- `RX_DATA`  out  8  last received byte, LSB first on the line; bit 7 is 0 in 7-bit mode.
- `RX_RDY`  out  1  a byte is held and not yet acknowledged.
- `PERR`  out  1  parity error on the held byte; always 0 when parity was disabled.
- `FERR`  out  1  stop bit sampled low on the held byte.
- `OVF`  out  1  a frame completed while `RX_RDY` was set and not being cleared.

## Operation
- `RX` passes through a 2-flop synchronizer. All sampling uses the synchronized value `rxs`.
- The block latches `PEN`, `EIGHT`, `OHEL` and `BAUD_COUNT` on the IDLE→START transition. Input changes mid-frame have no effect.
- Bits after start: N = 7 + EIGHT + PEN, followed by 1 stop bit.
- State IDLE:
  - If `BAUD_COUNT` < 4, the block stays in IDLE and ignores `RX`.
  - Otherwise, `rxs`=0 moves to START, clears the bit-time counter and clears the bit index.
- State START:
  - When the counter reaches `BAUD_COUNT`[18:1]−1 (mid start bit), sample `rxs`.
  - Sample = 1 is a false start: return to IDLE with no output change.
  - Sample = 0 moves to DATA and clears the counter.
- State DATA:
  - When the counter reaches `BAUD_COUNT`−1, sample `rxs` into a shift register (LSB first), clear the counter and increment the index.
  - After N samples, go to STOP.
  - The parity bit, if enabled, is the last DATA sample. It is kept separately and is not placed in `RX_DATA`.
- State STOP:
  - When the counter reaches `BAUD_COUNT`−1, sample the stop bit.
  - Next cycle ("commit"):
    - `RX_DATA` ← data bits.
    - `FERR` ← ~stop.
    - `PERR` ← PEN & (XOR(data bits, parity) ≠ OHEL).
    - `OVF` ← `RX_RDY` & ~`CLR_RXRDY`.
    - `RX_RDY` ← 1.
  - Then return to IDLE.
- A stop bit sampled low still commits, with `FERR`=1. If the line stays low, IDLE immediately starts a new frame.
- `CLR_RXRDY` outside a commit cycle clears `RX_RDY`, `PERR`, `FERR` and `OVF` on the next edge. `RX_DATA` holds its value.
- `CLR_RXRDY` in the same cycle as a commit: the commit wins. The new byte and flags load, `RX_RDY`=1 and `OVF`=0.
- On overrun, the newer byte overwrites `RX_DATA`.

## Timing
- Reset values: `RX_DATA`=0, `RX_RDY`=0, `PERR`=0, `FERR`=0, `OVF`=0, state IDLE, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. The first frame after release needs a fresh falling edge.
- Pin falling edge to `rxs` low: 2 clocks.
- Data bit k (k=0..N−1) is sampled `BAUD_COUNT`/2 + (k+1)·`BAUD_COUNT` clocks after `rxs` falls, i.e. at mid-bit.
- `RX_RDY` rises at 1 + `BAUD_COUNT`/2 + (N+1)·`BAUD_COUNT` + 2 clocks after the pin falling edge, within ±1 clock.
- `RX_RDY` falls 1 clock after `CLR_RXRDY`.
- The block returns to IDLE mid stop bit, which tolerates back-to-back frames and up to ±4% baud mismatch at N=9.
- Counter: 19 bits, no wrap within a bit; it clears on every sample.

## Test plan
- Loopback with the transmit stage: `BAUD_COUNT`=16, EIGHT=1, PEN=1, OHEL=0, byte 0xA5 → `RX_DATA`=0xA5, `RX_RDY`=1, `PERR`=0, `FERR`=0, `OVF`=0. Then pulse `CLR_RXRDY` → all flags 0 next cycle.
- 7-bit odd parity: EIGHT=0, PEN=1, OHEL=1, drive 0x7F with a wrong parity bit → `RX_DATA`=0x7F, `PERR`=1. With the correct parity bit → `PERR`=0.
- Framing and false start:
  - Drive a stop bit low → `FERR`=1.
  - Drive a 5-clock low glitch at `BAUD_COUNT`=16 → stays IDLE, `RX_RDY` stays 0.
- Overrun: two frames, 0x11 then 0x22, with no `CLR_RXRDY` → `RX_DATA`=0x22, `OVF`=1. Repeat with `CLR_RXRDY` on the commit cycle → `OVF`=0, `RX_RDY`=1.
- Reset mid-frame: drop `reset` during DATA and release → all outputs 0. A following frame 0x3C is received correctly.
- Config latch and minimum baud:
  - Toggle `EIGHT` mid-frame → frame decodes with the latched setting.
  - `BAUD_COUNT`=2 → no reception.
